// File: rtl/uart_apb_pkg.sv
// Shared constants for the UART APB requester: FSM state encodings and UART register offsets.
package uart_apb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [7:0] UART_CON = 8'h00;
    localparam logic [7:0] UART_SE  = 8'h04;
    localparam logic [7:0] UART_BR  = 8'h08;
    localparam logic [7:0] UART_DT  = 8'h0C;
    localparam logic [7:0] UART_IE  = 8'h10;
    localparam logic [7:0] UART_IS  = 8'h14;
    localparam logic [7:0] UART_IF  = 8'h18;

    // Highest valid register offset; anything above it is reserved.
    localparam logic [7:0] UART_TOP_OFFSET = 8'h18;

endpackage

// File: rtl/uart_apb_wait_timer.sv
// Counts ACCESS cycles with pready low and flags when TIMEOUT of them have elapsed.
module uart_apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic en,
    output logic expired_c
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

            logic [CNT_W-1:0] cnt;

            always_ff @(posedge pclk) begin
                if (preset || clear) begin
                    cnt <= '0;
                end else if (en && !expired_c) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            assign expired_c = (cnt == CNT_W'(TIMEOUT));
        end else begin : g_no_timer
            assign expired_c = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/uart_apb_master.sv
// APB4 requester: turns one command at a time into a single APB transfer with a wait-state timeout.
module uart_apb_master
    import uart_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout
);

    logic [1:0] state;
    logic [1:0] state_d;
    logic       accept_c;
    logic       done_c;
    logic       abort_c;
    logic       expired_c;

    assign cmd_ready = (state == ST_IDLE);

    uart_apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk      (pclk),
        .preset    (preset),
        .clear     (accept_c),
        .en        ((state == ST_ACCESS) && !pready),
        .expired_c (expired_c)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // pready on the expiry cycle takes priority over the timeout abort.
    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        done_c   = 1'b0;
        abort_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_c = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end else if (expired_c) begin
                    abort_c = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus and response registers; reads drive zero write data and strobes.
    always_ff @(posedge pclk) begin
        if (preset) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            psel      <= (state_d != ST_IDLE);
            penable   <= (state_d == ST_ACCESS);
            rsp_valid <= done_c || abort_c;
            if (accept_c) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_write ? cmd_wdata : '0;
                pstrb  <= cmd_write ? cmd_strb : '0;
            end
            if (done_c) begin
                rsp_rdata   <= pwrite ? '0 : prdata;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
            end else if (abort_c) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_master.sv
// Scoreboard bench for uart_apb_master driving a behavioural UART register slave.
module tb_uart_apb_master;
    import uart_apb_pkg::*;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        logic [7:0]  lat;
    } exp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          at;
    } rsp_t;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;

    int n_pass = 0;
    int n_total = 0;

    always #5 pclk = ~pclk;

    uart_apb_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout)
    );

    // UART slave: word-aligned offsets up to the top register, full-word writes only.
    logic [31:0] regs [0:7];
    int          wait_cfg = 0;
    bit          hang = 1'b0;
    int          wcnt = 0;
    logic        bad;

    always_comb begin
        bad     = (paddr[1:0] != 2'b00) || (paddr > 32'(UART_TOP_OFFSET)) || (pwrite && pstrb != 4'hF);
        pready  = psel && penable && !hang && (wcnt >= wait_cfg);
        pslverr = pready && bad;
        prdata  = (!bad || pwrite) ? regs[paddr[4:2]] : 32'h0;
    end

    always @(posedge pclk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (pready && pwrite && !bad) regs[paddr[4:2]] <= pwdata;
    end

    // Monitor: accepts, responses, psel burst lengths and bus protocol checks.
    int          cyc = 0;
    int          proto_err = 0;
    int          psel_run = 0;
    int          acc_q[$];
    rsp_t        rsp_q[$];
    exp_t        exp_q[$];
    int          psel_len_q[$];
    logic        psel_p = 1'b0;
    logic [68:0] bus_p = '0;
    logic [3:0]  bus_strb = '0;
    logic [31:0] bus_wdata = '0;

    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (!preset && cmd_valid && cmd_ready === 1'b1) acc_q.push_back(cyc);
        if (rsp_valid === 1'b1) rsp_q.push_back('{rsp_rdata, rsp_err, rsp_timeout, cyc});
        if ((penable === 1'b1 && psel !== 1'b1) ||
            (psel === 1'b1 && psel_p !== 1'b1 && penable === 1'b1) ||
            (psel === 1'b1 && psel_p === 1'b1 && {pwrite, paddr, pwdata, pstrb} !== bus_p))
            proto_err <= proto_err + 1;
        if (psel === 1'b1 && penable === 1'b1) begin
            bus_strb  <= pstrb;
            bus_wdata <= pwdata;
        end
        if (psel === 1'b1) psel_run <= psel_run + 1;
        else if (psel_run != 0) begin
            psel_len_q.push_back(psel_run);
            psel_run <= 0;
        end
        psel_p <= psel;
        bus_p  <= {pwrite, paddr, pwdata, pstrb};
    end

    function automatic exp_t mk(input logic [31:0] rdata, input logic err, input logic tmo, input int lat);
        return '{rdata, err, tmo, 8'(lat)};
    endfunction

    task automatic clear_queues();
        acc_q.delete();
        rsp_q.delete();
        exp_q.delete();
        psel_len_q.delete();
    endtask

    task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_valid = 1'b1;
        for (int n = 0; n < 100 && cmd_ready !== 1'b1; n++) begin
            @(posedge pclk);
            #1;
        end
        @(posedge pclk);
        #1;
        cmd_valid = hold;
    endtask

    task automatic collect(input int n, output bit ok);
        for (int t = 0; t < 200 && rsp_q.size() < n; t++) begin
            @(posedge pclk);
            #1;
        end
        ok = (rsp_q.size() >= n);
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        n_total++;
        if ({psel, penable, rsp_valid, cmd_ready, rsp_err, rsp_timeout, pwrite} !== 7'b0001000)
            $display("FAIL reset_ctrl got %b want 0001000", {psel, penable, rsp_valid, cmd_ready, rsp_err, rsp_timeout, pwrite});
        else n_pass++;
        n_total++;
        if ({paddr, pwdata, pstrb, rsp_rdata} !== 100'h0)
            $display("FAIL reset_data got paddr=%h pwdata=%h pstrb=%h rdata=%h want all 0", paddr, pwdata, pstrb, rsp_rdata);
        else n_pass++;
        preset = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        n_total++;
        if ({psel, cmd_ready} !== 2'b01) $display("FAIL idle_after_reset got psel,cmd_ready=%b want 01", {psel, cmd_ready});
        else n_pass++;
    endtask

    task automatic test_write_read();
        rsp_t r; exp_t e, got; int a; bit ok;
        clear_queues();
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0, 3));
        send(1'b1, 32'(UART_BR), 32'h0000_001F, 4'hF, 1'b0);
        exp_q.push_back(mk(32'h0000_001F, 1'b0, 1'b0, 3));
        send(1'b0, 32'(UART_BR), 32'h0, 4'h0, 1'b0);
        collect(2, ok);
        n_total++;
        if (!ok) $display("FAIL wr_rd_count got %0d responses want 2", rsp_q.size()); else n_pass++;
        while (rsp_q.size() != 0 && exp_q.size() != 0 && acc_q.size() != 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front(); a = acc_q.pop_front();
            got = '{r.rdata, r.err, r.tmo, 8'(r.at - a)};
            n_total++;
            if (got !== e) $display("FAIL wr_rd_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                                    got.rdata, got.err, got.tmo, got.lat, e.rdata, e.err, e.tmo, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        rsp_t r; exp_t e, got; int a; bit ok; int len;
        clear_queues();
        exp_q.push_back(mk(32'h0, 1'b1, 1'b0, 3));
        send(1'b0, 32'h1C, 32'h0, 4'h0, 1'b0);
        exp_q.push_back(mk(32'h0, 1'b1, 1'b0, 3));
        send(1'b1, 32'h05, 32'hFFFF_FFFF, 4'hF, 1'b0);
        collect(2, ok);
        len = (psel_len_q.size() != 0) ? psel_len_q[0] : -1;
        n_total++;
        if (len != 2) $display("FAIL reserved_psel_len got %0d want 2", len); else n_pass++;
        while (rsp_q.size() != 0 && exp_q.size() != 0 && acc_q.size() != 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front(); a = acc_q.pop_front();
            got = '{r.rdata, r.err, r.tmo, 8'(r.at - a)};
            n_total++;
            if (got !== e) $display("FAIL err_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                                    got.rdata, got.err, got.tmo, got.lat, e.rdata, e.err, e.tmo, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_strobes();
        rsp_t r; exp_t e, got; int a; bit ok;
        clear_queues();
        exp_q.push_back(mk(32'hC0DE_0000, 1'b0, 1'b0, 3));
        send(1'b0, 32'(UART_CON), 32'hDEAD_BEEF, 4'hF, 1'b0);
        collect(1, ok);
        n_total++;
        if ({bus_strb, bus_wdata} !== 36'h0) $display("FAIL read_bus got pstrb=%h pwdata=%h want 0 0", bus_strb, bus_wdata);
        else n_pass++;
        exp_q.push_back(mk(32'h0, 1'b1, 1'b0, 3));
        send(1'b1, 32'(UART_CON), 32'h1234_5678, 4'h3, 1'b0);
        collect(2, ok);
        n_total++;
        if ({bus_strb, bus_wdata} !== {4'h3, 32'h1234_5678})
            $display("FAIL write_bus got pstrb=%h pwdata=%h want 3 12345678", bus_strb, bus_wdata);
        else n_pass++;
        while (rsp_q.size() != 0 && exp_q.size() != 0 && acc_q.size() != 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front(); a = acc_q.pop_front();
            got = '{r.rdata, r.err, r.tmo, 8'(r.at - a)};
            n_total++;
            if (got !== e) $display("FAIL strb_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                                    got.rdata, got.err, got.tmo, got.lat, e.rdata, e.err, e.tmo, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        rsp_t r; exp_t e, got; int a; bit ok; int len;
        clear_queues();
        wait_cfg = 5;
        exp_q.push_back(mk(32'h0000_001F, 1'b0, 1'b0, 8));
        send(1'b0, 32'(UART_BR), 32'h0, 4'h0, 1'b0);
        collect(1, ok);
        len = (psel_len_q.size() != 0) ? psel_len_q[0] : -1;
        n_total++;
        if (len != 7) $display("FAIL wait5_psel_len got %0d want 7", len); else n_pass++;
        // pready lands on the same cycle the timer expires: must complete normally.
        wait_cfg = int'(TIMEOUT);
        exp_q.push_back(mk(32'h0000_001F, 1'b0, 1'b0, 19));
        send(1'b0, 32'(UART_BR), 32'h0, 4'h0, 1'b0);
        collect(2, ok);
        wait_cfg = 0;
        while (rsp_q.size() != 0 && exp_q.size() != 0 && acc_q.size() != 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front(); a = acc_q.pop_front();
            got = '{r.rdata, r.err, r.tmo, 8'(r.at - a)};
            n_total++;
            if (got !== e) $display("FAIL wait_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                                    got.rdata, got.err, got.tmo, got.lat, e.rdata, e.err, e.tmo, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        rsp_t r; exp_t e, got; int a; bit ok; int len;
        clear_queues();
        hang = 1'b1;
        exp_q.push_back(mk(32'h0, 1'b1, 1'b1, 19));
        send(1'b0, 32'(UART_SE), 32'h0, 4'h0, 1'b0);
        collect(1, ok);
        hang = 1'b0;
        len = (psel_len_q.size() != 0) ? psel_len_q[0] : -1;
        n_total++;
        if (len != 18) $display("FAIL timeout_psel_len got %0d want 18", len); else n_pass++;
        while (rsp_q.size() != 0 && exp_q.size() != 0 && acc_q.size() != 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front(); a = acc_q.pop_front();
            got = '{r.rdata, r.err, r.tmo, 8'(r.at - a)};
            n_total++;
            if (got !== e) $display("FAIL timeout_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                                    got.rdata, got.err, got.tmo, got.lat, e.rdata, e.err, e.tmo, e.lat);
            else n_pass++;
        end
        repeat (3) @(posedge pclk);
        #1;
        n_total++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b011, 32'h0})
            $display("FAIL timeout_hold got valid=%b err=%b tmo=%b rdata=%h want 0 1 1 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        rsp_t r; exp_t e, got; int a; bit ok; int d1, d2;
        clear_queues();
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0, 3));
        send(1'b1, 32'(UART_IE), 32'h0000_00A5, 4'hF, 1'b1);
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0, 3));
        send(1'b1, 32'(UART_DT), 32'h0000_003C, 4'hF, 1'b1);
        exp_q.push_back(mk(32'h0000_00A5, 1'b0, 1'b0, 3));
        send(1'b0, 32'(UART_IE), 32'h0, 4'h0, 1'b0);
        collect(3, ok);
        d1 = (acc_q.size() >= 3) ? acc_q[1] - acc_q[0] : -1;
        d2 = (acc_q.size() >= 3) ? acc_q[2] - acc_q[1] : -1;
        n_total++;
        if (d1 != 3 || d2 != 3) $display("FAIL b2b_spacing got %0d,%0d want 3,3", d1, d2); else n_pass++;
        while (rsp_q.size() != 0 && exp_q.size() != 0 && acc_q.size() != 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front(); a = acc_q.pop_front();
            got = '{r.rdata, r.err, r.tmo, 8'(r.at - a)};
            n_total++;
            if (got !== e) $display("FAIL b2b_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                                    got.rdata, got.err, got.tmo, got.lat, e.rdata, e.err, e.tmo, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        rsp_t r; exp_t e, got; int a; bit ok;
        clear_queues();
        hang = 1'b1;
        send(1'b0, 32'(UART_BR), 32'h0, 4'h0, 1'b0);
        for (int n = 0; n < 10 && penable !== 1'b1; n++) begin
            @(posedge pclk);
            #1;
        end
        preset = 1'b1;
        @(posedge pclk);
        #1;
        preset = 1'b0;
        n_total++;
        if ({psel, penable, cmd_ready, rsp_valid} !== 4'b0010)
            $display("FAIL mid_reset_bus got psel,penable,cmd_ready,rsp_valid=%b want 0010", {psel, penable, cmd_ready, rsp_valid});
        else n_pass++;
        repeat (5) @(posedge pclk);
        #1;
        n_total++;
        if (rsp_q.size() != 0) $display("FAIL mid_reset_rsp got %0d responses want 0", rsp_q.size()); else n_pass++;
        hang = 1'b0;
        clear_queues();
        exp_q.push_back(mk(32'h0000_001F, 1'b0, 1'b0, 3));
        send(1'b0, 32'(UART_BR), 32'h0, 4'h0, 1'b0);
        collect(1, ok);
        n_total++;
        if (!ok) $display("FAIL after_reset_count got %0d responses want 1", rsp_q.size()); else n_pass++;
        while (rsp_q.size() != 0 && exp_q.size() != 0 && acc_q.size() != 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front(); a = acc_q.pop_front();
            got = '{r.rdata, r.err, r.tmo, 8'(r.at - a)};
            n_total++;
            if (got !== e) $display("FAIL after_reset_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                                    got.rdata, got.err, got.tmo, got.lat, e.rdata, e.err, e.tmo, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_protocol();
        n_total++;
        if (proto_err != 0) $display("FAIL apb_protocol got %0d violations want 0", proto_err); else n_pass++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 32'hC0DE_0000 | 32'(i);
        #1;
        test_reset();
        test_write_read();
        test_errors();
        test_strobes();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
